ahblite_uart_fifo: RTL and testbench

Parametrised AHB-Lite UART peripheral: 8N1 transmitter and receiver with programmable baud divisor, TX/RX FIFOs of configurable depth, sticky error flags and a single maskable level interrupt. Sits on one interconnect slave port, drives one IRQ line of the Cortex-M0, and replaces the fixed-rate, unbuffered UART interface/TX/RX/baud-generator group in the SoC.

---
 rtl/ahblite_uart_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ahblite_uart_fifo.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_uart_fifo.sv
// AHB-Lite UART: 8N1 transmitter/receiver with programmable divisor, TX/RX FIFOs,
// sticky error flags and one maskable level interrupt. Zero-wait-state slave.
module ahblite_uart_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        RXD,
  output logic        TXD,
  output logic        IRQ
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAITH = 3'd4;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{HTRANS[0], HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA};

  // Address phase is registered; the access takes effect in the following data phase.
  logic       dp_valid;
  logic       dp_write;
  logic [1:0] dp_addr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_valid <= HSEL & HTRANS[1] & HREADY;
      dp_write <= HWRITE;
      dp_addr  <= HADDR[3:2];
    end
  end

  logic wr_data, wr_status, wr_ctrl, wr_div, rd_data;
  assign wr_data   = dp_valid &  dp_write & (dp_addr == 2'd0);
  assign wr_status = dp_valid &  dp_write & (dp_addr == 2'd1);
  assign wr_ctrl   = dp_valid &  dp_write & (dp_addr == 2'd2);
  assign wr_div    = dp_valid &  dp_write & (dp_addr == 2'd3);
  assign rd_data   = dp_valid & ~dp_write & (dp_addr == 2'd0);

  logic [2:0]           ctrl;
  logic [DIV_WIDTH-1:0] div_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl    <= 3'd0;
      div_reg <= DIV_RST;
    end else begin
      if (wr_ctrl) ctrl <= HWDATA[2:0];
      if (wr_div) div_reg <= (HWDATA[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : HWDATA[DIV_WIDTH-1:0];
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;

  assign tx_full    = (tx_cnt == DEPTH_C);
  assign tx_empty   = (tx_cnt == '0);
  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wp] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + CW'(1);
      else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - CW'(1);
    end
  end

  // TX FSM; STOP chains straight into START when another byte is queued.
  logic [1:0]           tx_state;
  logic [DIV_WIDTH-1:0] tx_tmr, tx_div;
  logic [7:0]           tx_shift;
  logic [2:0]           tx_idx;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_tmr == tx_div - ONE);
  assign tx_pop     = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_div   <= DIV_RST;
      tx_shift <= 8'd0;
      tx_idx   <= 3'd0;
      TXD      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_tmr   <= '0;
            tx_div   <= div_reg;
            tx_shift <= tx_mem[tx_rp];
            TXD      <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_tmr   <= '0;
            tx_idx   <= 3'd0;
            TXD      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_tmr <= tx_tmr + ONE;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_tmr <= '0;
            if (tx_idx == 3'd7) begin
              tx_state <= TX_STOP;
              TXD      <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              TXD      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_tmr <= tx_tmr + ONE;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_tmr <= '0;
            if (tx_pop) begin
              tx_state <= TX_START;
              tx_div   <= div_reg;
              tx_shift <= tx_mem[tx_rp];
              TXD      <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_tmr <= tx_tmr + ONE;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          TXD      <= 1'b1;
        end
      endcase
    end
  end

  // RX line synchroniser, idles high.
  logic rx_meta, rx_s;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rx_s    <= rx_meta;
    end
  end

  logic [2:0]           rx_state;
  logic [DIV_WIDTH-1:0] rx_tmr, rx_div;
  logic [7:0]           rx_shift;
  logic [2:0]           rx_idx;
  logic                 rx_push_q, rx_ferr_q, rx_bit_end, rx_half_end;

  assign rx_bit_end  = (rx_tmr == rx_div - ONE);
  assign rx_half_end = (rx_tmr == (rx_div >> 1) - ONE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_state  <= RX_IDLE;
      rx_tmr    <= '0;
      rx_div    <= DIV_RST;
      rx_shift  <= 8'd0;
      rx_idx    <= 3'd0;
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_tmr   <= '0;
            rx_div   <= div_reg;
          end
        end
        RX_START: begin
          if (rx_half_end) begin
            rx_tmr   <= '0;
            rx_idx   <= 3'd0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tmr <= rx_tmr + ONE;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_tmr   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_tmr <= rx_tmr + ONE;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_tmr <= '0;
            if (rx_s) begin
              rx_push_q <= 1'b1;
              rx_state  <= RX_IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
              rx_state  <= RX_WAITH;
            end
          end else begin
            rx_tmr <= rx_tmr + ONE;
          end
        end
        RX_WAITH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // RX FIFO; the received byte stays in rx_shift until the next frame's data bits.
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovf_set;

  assign rx_full    = (rx_cnt == DEPTH_C);
  assign rx_empty   = (rx_cnt == '0);
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_push    = rx_push_q & (~rx_full | rx_pop);
  assign rx_ovf_set = rx_push_q & rx_full & ~rx_pop;

  always_ff @(posedge HCLK) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + CW'(1);
      else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - CW'(1);
    end
  end

  // Sticky flags: a set event in the same cycle as a clear keeps the flag set.
  logic       rx_ovf, frame_err, tx_ovf;
  logic [2:0] clr;
  assign clr = wr_status ? HWDATA[6:4] : 3'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      IRQ       <= 1'b0;
    end else begin
      rx_ovf    <= rx_ovf_set | (rx_ovf & ~clr[0]);
      frame_err <= rx_ferr_q  | (frame_err & ~clr[1]);
      tx_ovf    <= tx_ovf_set | (tx_ovf & ~clr[2]);
      IRQ       <= (ctrl[0] & tx_empty) | (ctrl[1] & ~rx_empty) |
                   (ctrl[2] & (rx_ovf | frame_err | tx_ovf));
    end
  end

  logic [7:0] status;
  assign status = {(tx_state != TX_IDLE), tx_ovf, frame_err, rx_ovf,
                   rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid & ~dp_write) begin
      case (dp_addr)
        2'd0:    HRDATA[7:0] = rx_empty ? 8'd0 : rx_mem[rx_rp];
        2'd1:    HRDATA[7:0] = status;
        2'd2:    HRDATA[2:0] = ctrl;
        default: HRDATA[DIV_WIDTH-1:0] = div_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_uart_fifo.sv
// Bench for ahblite_uart_fifo: AHB driver tasks, read scoreboard, TX frame decoder,
// RX line driver and a queue-based model of FIFOs and flags.
module tb_ahblite_uart_fifo;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic [3:0]  HPROT = 4'b0011;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HADDR = 32'd0;
  logic [31:0] HWDATA = 32'd0;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic        RXD = 1'b1;
  logic        TXD, IRQ;

  ahblite_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DEFAULT_DIV(434)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HPROT(HPROT), .HWRITE(HWRITE), .HREADY(HREADY), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .RXD(RXD), .TXD(TXD), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model
  logic [7:0] m_rxq[$];
  logic [7:0] tx_exp_q[$];
  bit         m_rx_ovf, m_ferr, m_tx_ovf, m_tx_busy;
  int         m_tx_fifo;
  logic [2:0] m_ctrl;
  int         cur_div = 434;
  bit         tx_mon_en = 1'b1;

  function automatic logic [31:0] exp_status();
    return {24'd0, m_tx_busy, m_tx_ovf, m_ferr, m_rx_ovf, (m_rxq.size() == DEPTH),
            (m_rxq.size() == 0), (m_tx_fifo == 0), (m_tx_fifo == DEPTH)};
  endfunction

  function automatic logic exp_irq();
    return (m_ctrl[0] && m_tx_fifo == 0) || (m_ctrl[1] && m_rxq.size() != 0) ||
           (m_ctrl[2] && (m_rx_ovf || m_ferr || m_tx_ovf));
  endfunction

  function automatic logic [31:0] m_rx_pop();
    if (m_rxq.size() == 0) return 32'd0;
    return {24'd0, m_rxq.pop_front()};
  endfunction

  function automatic void m_rx_accept(input logic [7:0] b);
    if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
    else m_rx_ovf = 1'b1;
  endfunction

  // Read scoreboard: expectations queued at issue, compared in the data phase.
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          rd_dp;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_dp = 1'b0;
    else rd_dp = HSEL && HTRANS[1] && HREADY && !HWRITE;
  end

  always @(negedge HCLK) begin
    if (rd_dp) begin
      if (exp_q.size() == 0) chk("unexpected_read", HRDATA, 32'hDEAD_BEEF);
      else chk(name_q.pop_front(), HRDATA, exp_q.pop_front());
    end
  end

  // TX frame decoder: samples mid-bit at the current divisor.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    int         d;
    prev = 1'b1;
    forever begin
      @(negedge HCLK);
      if (prev && !TXD && tx_mon_en && HRESETn) begin
        d = cur_div;
        repeat (d / 2) @(negedge HCLK);
        chk_bit("tx_start_bit", TXD, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge HCLK);
          b[i] = TXD;
        end
        repeat (d) @(negedge HCLK);
        chk_bit("tx_stop_bit", TXD, 1'b1);
        if (tx_exp_q.size() == 0) chk("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
        prev = 1'b1;
      end else begin
        prev = TXD;
      end
    end
  end

  // Driver: HWDATA for the previous address phase goes out with the next control.
  logic [31:0] pend_wdata = 32'd0;

  task automatic bus_cycle(input bit act, input bit wr, input logic [3:0] addr, input logic [31:0] wd);
    @(negedge HCLK);
    HWDATA = pend_wdata;
    HSEL   = act;
    HTRANS = act ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = {28'd0, addr};
    pend_wdata = wd;
  endtask

  task automatic rd_issue(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus_cycle(1'b1, 1'b0, addr, 32'd0);
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] d);
    bus_cycle(1'b1, 1'b1, addr, d);
    bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic ahb_read(input logic [3:0] addr, input logic [31:0] exp, input string nm);
    rd_issue(addr, exp, nm);
    bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic set_div(input int d);
    ahb_write(4'hC, 32'(d));
    cur_div = (d < 4) ? 4 : d;
  endtask

  task automatic set_ctrl(input logic [2:0] c);
    ahb_write(4'h8, {29'd0, c});
    m_ctrl = c;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop, input int tail);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge HCLK);
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (cur_div) @(negedge HCLK);
    end
    repeat (tail) @(negedge HCLK);
    RXD = 1'b1;
    repeat (4) @(negedge HCLK);
  endtask

  // Called in the middle of the first start-bit cycle; checks every cycle of nf frames.
  task automatic tx_wave(input string nm, input logic [23:0] bytes, input int nf, input int d);
    int bad, f, j;
    logic e;
    logic [7:0] cur;
    bad = 0;
    for (int k = 0; k < nf * 10 * d; k++) begin
      f = k / (10 * d);
      j = (k % (10 * d)) / d;
      cur = bytes[8*f +: 8];
      if (j == 0) e = 1'b0;
      else if (j == 9) e = 1'b1;
      else e = cur[j-1];
      if (TXD !== e) bad++;
      if (k < nf * 10 * d - 1) @(negedge HCLK);
    end
    chk(nm, 32'(bad), 32'd0);
  endtask

  task automatic settle_and_check(input string nm);
    repeat (3) @(negedge HCLK);
    chk_bit({nm, "_irq"}, IRQ, exp_irq());
    ahb_read(4'h4, exp_status(), {nm, "_status"});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] rb;
    logic [7:0] tx_bytes[$];
    int n;

    m_ctrl = 3'd0;
    repeat (3) @(negedge HCLK);
    chk_bit("rst_txd", TXD, 1'b1);
    chk_bit("rst_irq", IRQ, 1'b0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk_bit("rst_hreadyout", HREADYOUT, 1'b1);
    chk_bit("rst_hresp", HRESP, 1'b0);
    HRESETn = 1'b1;
    ahb_read(4'h4, exp_status(), "rst_status");
    ahb_read(4'h8, 32'd0, "rst_ctrl");
    ahb_read(4'hC, 32'd434, "rst_div");

    set_div(2);
    ahb_read(4'hC, 32'd4, "div_clamp");
    set_div(8);
    ahb_read(4'hC, 32'd8, "div_8");

    // Single frame 0x55, exact waveform from N+2.
    tx_exp_q.push_back(8'h55);
    ahb_write(4'h0, 32'h55);
    @(negedge HCLK);
    chk_bit("txd_n1_high", TXD, 1'b1);
    @(negedge HCLK);
    tx_wave("tx_wave_55", {16'd0, 8'h55}, 1, 8);
    @(negedge HCLK);
    chk_bit("txd_after_frame", TXD, 1'b1);
    ahb_read(4'h4, exp_status(), "status_after_55");

    // Three back-to-back writes: contiguous frames.
    tx_exp_q.push_back(8'hA1);
    tx_exp_q.push_back(8'hB2);
    tx_exp_q.push_back(8'hC3);
    bus_cycle(1'b1, 1'b1, 4'h0, 32'hA1);
    bus_cycle(1'b1, 1'b1, 4'h0, 32'hB2);
    bus_cycle(1'b1, 1'b1, 4'h0, 32'hC3);
    bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
    tx_wave("tx_wave_3frames", {8'hC3, 8'hB2, 8'hA1}, 3, 8);
    @(negedge HCLK);
    chk_bit("txd_after_3frames", TXD, 1'b1);
    settle_and_check("after_3frames");

    // Single RX frame with RX interrupt.
    set_ctrl(3'b010);
    settle_and_check("rx_idle");
    rx_frame(8'h3C, 1'b1, 0);
    m_rx_accept(8'h3C);
    settle_and_check("rx_3c");
    ahb_read(4'h0, m_rx_pop(), "rx_data_3c");
    settle_and_check("rx_3c_popped");

    // DEPTH+1 unread random frames: overflow.
    for (int i = 0; i <= DEPTH; i++) begin
      rb = 8'($urandom_range(0, 255));
      rx_frame(rb, 1'b1, 0);
      m_rx_accept(rb);
    end
    settle_and_check("rx_overflow");
    ahb_write(4'h4, 32'h10);
    m_rx_ovf = 1'b0;
    settle_and_check("rx_ovf_cleared");
    for (int i = 0; i <= DEPTH; i++) rd_issue(4'h0, m_rx_pop(), "rx_drain");
    bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
    settle_and_check("rx_drained");

    // Framing error, line held low past the stop bit, then recovery.
    set_ctrl(3'b100);
    rx_frame(8'($urandom_range(0, 255)), 1'b0, 3 * cur_div);
    m_ferr = 1'b1;
    settle_and_check("frame_err");
    ahb_write(4'h4, 32'h20);
    m_ferr = 1'b0;
    settle_and_check("frame_err_cleared");
    @(negedge HCLK);
    RXD = 1'b0;
    repeat (2) @(negedge HCLK);
    RXD = 1'b1;
    repeat (40) @(negedge HCLK);
    settle_and_check("glitch");
    rb = 8'($urandom_range(0, 255));
    rx_frame(rb, 1'b1, 0);
    m_rx_accept(rb);
    settle_and_check("rx_recovered");
    ahb_read(4'h0, m_rx_pop(), "rx_data_recovered");

    // Random bytes at a random divisor.
    set_div($urandom_range(4, 12));
    n = $urandom_range(3, 5);
    for (int i = 0; i < n; i++) begin
      rb = 8'($urandom_range(0, 255));
      tx_exp_q.push_back(rb);
      ahb_write(4'h0, {24'd0, rb});
      repeat ($urandom_range(0, 30)) @(negedge HCLK);
    end
    repeat (n * 10 * cur_div + 20) @(negedge HCLK);
    settle_and_check("tx_random_done");

    // TX overflow: transmitter holds one byte, FIFO holds DEPTH, the rest drop.
    set_div(40);
    set_ctrl(3'b001);
    settle_and_check("tx_irq_idle");
    for (int i = 0; i < DEPTH + 2; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (i <= DEPTH) tx_exp_q.push_back(rb);
      bus_cycle(1'b1, 1'b1, 4'h0, {24'd0, rb});
    end
    bus_cycle(1'b0, 1'b0, 4'h0, 32'd0);
    m_tx_fifo = DEPTH;
    m_tx_busy = 1'b1;
    m_tx_ovf  = 1'b1;
    settle_and_check("tx_overflow");
    repeat ((DEPTH + 1) * 10 * cur_div + 50) @(negedge HCLK);
    m_tx_fifo = 0;
    m_tx_busy = 1'b0;
    settle_and_check("tx_drained");
    ahb_write(4'h4, 32'h40);
    m_tx_ovf = 1'b0;
    settle_and_check("tx_ovf_cleared");
    chk("tx_frames_seen", 32'(tx_exp_q.size()), 32'd0);

    // Reset in the middle of a frame.
    set_div(8);
    tx_mon_en = 1'b0;
    ahb_write(4'h0, 32'h00);
    repeat (22) @(negedge HCLK);
    chk_bit("txd_mid_frame_low", TXD, 1'b0);
    chk_bit("irq_before_reset", IRQ, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_bit("txd_async_reset", TXD, 1'b1);
    chk_bit("irq_async_reset", IRQ, 1'b0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    pend_wdata = 32'd0;
    m_ctrl = 3'd0;
    cur_div = 434;
    settle_and_check("post_reset");
    ahb_read(4'h8, 32'd0, "post_reset_ctrl");
    ahb_read(4'hC, 32'd434, "post_reset_div");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge HCLK);
    chk("reads_completed", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
